aqed_rd_checker: RTL and testbench

Read-side A-QED self-consistency checker for the memory core. It sits between the read-request source and the core's read port, mirroring the write-side A-QED wrapper. On `exec_dup` it tags one read as the original and re-issues its address as a duplicate read. It captures both in-order read responses and flags a mismatch, an intervening write (abort), a missing duplicate response (hang) or an unsolicited response (protocol error).

---
 rtl/aqed_rd_checker_if.sv | 25 ++
 rtl/aqed_rd_checker.sv | 130 +++++++++++++
 tb/tb_aqed_rd_checker.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aqed_rd_checker_if.sv
// Read-request / read-response bundle between the request source, the
// A-QED read checker and the memory core read port.
interface aqed_rd_checker_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  ren_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  ren_ready;
  logic                  ren_out;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;

  // The checker drives the core read port and the source back-pressure.
  modport master (
    input  ren_in, addr_in, valid_in, data_in,
    output ren_ready, ren_out, addr_out
  );

  modport slave (
    output ren_in, addr_in, valid_in, data_in,
    input  ren_ready, ren_out, addr_out
  );
endinterface

// File: rtl/aqed_rd_checker.sv
// Read-side A-QED checker: tags one read as original, replays its address as a
// duplicate and compares the two in-order responses.
module aqed_rd_checker #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int CNT_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              exec_dup,
  input  logic              wen_obs,
  aqed_rd_checker_if.master bus,
  output logic              qed_done,
  output logic              qed_check,
  output logic              qed_abort,
  output logic              qed_hang,
  output logic              proto_err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [OUT_W-1:0]     OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] SENTINEL = '1;

  typedef enum logic [2:0] {IDLE, ORIG, DUP, DONE, ABORT, HANG} state_t;

  state_t                state, state_nxt;
  logic [OUT_W-1:0]      outstanding;
  logic [CNT_WIDTH-1:0]  issue_cnt, rsp_cnt;
  logic [CNT_WIDTH-1:0]  orig_idx, dup_idx;
  logic [CNT_WIDTH-1:0]  orig_idx_eff, dup_idx_eff;
  logic [ADDR_WIDTH-1:0] orig_addr;
  logic [DATA_WIDTH-1:0] orig_data, dup_data;
  logic                  orig_got, dup_got;
  logic [TMR_W-1:0]      timer;
  logic                  timer_inc;
  logic                  proto_err_q;

  logic ready_i, issue, dup_sel, orig_tag, dup_tag;
  logic rsp_ok, orig_cap, dup_cap, both_next;

  // Request path is purely combinational; reset forces every output low.
  assign ready_i      = reset & (outstanding < OUT_MAX);
  assign issue        = bus.ren_in & ~flush & ready_i;
  assign dup_sel      = issue & exec_dup & (state == ORIG);
  assign orig_tag     = issue & exec_dup & (state == IDLE);
  assign dup_tag      = dup_sel & ~wen_obs;
  assign bus.ren_ready = ready_i;
  assign bus.ren_out   = issue;
  assign bus.addr_out  = !reset ? '0 : (dup_sel ? orig_addr : bus.addr_in);

  // A response issued in the same cycle as its own tagging must still match,
  // so compare against the index being latched this cycle.
  assign orig_idx_eff = orig_tag ? issue_cnt : orig_idx;
  assign dup_idx_eff  = dup_tag  ? issue_cnt : dup_idx;
  assign rsp_ok       = bus.valid_in & ((outstanding != '0) | issue);
  assign orig_cap     = rsp_ok & (orig_idx_eff != SENTINEL) & (rsp_cnt == orig_idx_eff);
  assign dup_cap      = rsp_ok & (dup_idx_eff != SENTINEL) & (rsp_cnt == dup_idx_eff);
  assign both_next    = (orig_got | orig_cap) & (dup_got | dup_cap);

  assign qed_done  = (state == DONE);
  assign qed_abort = (state == ABORT);
  assign qed_hang  = (state == HANG);
  assign qed_check = qed_done & (orig_data == dup_data);
  assign proto_err = proto_err_q;

  always_comb begin
    state_nxt = state;
    timer_inc = 1'b0;
    case (state)
      IDLE: if (orig_tag) state_nxt = ORIG;
      ORIG: begin
        if (wen_obs)      state_nxt = ABORT;
        else if (dup_sel) state_nxt = both_next ? DONE : DUP;
      end
      DUP: begin
        if (both_next)              state_nxt = DONE;
        else if (timer == TMR_LAST) state_nxt = HANG;
        else                        timer_inc = 1'b1;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      outstanding <= '0;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      orig_idx    <= SENTINEL;
      dup_idx     <= SENTINEL;
      orig_addr   <= '0;
      orig_data   <= '0;
      dup_data    <= '0;
      orig_got    <= 1'b0;
      dup_got     <= 1'b0;
      timer       <= '0;
      proto_err_q <= 1'b0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (issue)  issue_cnt <= issue_cnt + 1'b1;
      if (rsp_ok) rsp_cnt   <= rsp_cnt + 1'b1;
      if (issue && !rsp_ok)      outstanding <= outstanding + 1'b1;
      else if (rsp_ok && !issue) outstanding <= outstanding - 1'b1;
      if (bus.valid_in && !rsp_ok) proto_err_q <= 1'b1;
      if (orig_tag) begin
        orig_idx  <= issue_cnt;
        orig_addr <= bus.addr_in;
      end
      if (dup_tag) dup_idx <= issue_cnt;
      if (orig_cap) begin
        orig_data <= bus.data_in;
        orig_got  <= 1'b1;
      end
      if (dup_cap) begin
        dup_data <= bus.data_in;
        dup_got  <= 1'b1;
      end
      if (timer_inc)          timer <= timer + 1'b1;
      else if (state != DUP)  timer <= '0;
    end
  end

endmodule

// File: tb/tb_aqed_rd_checker.sv
// Bench for aqed_rd_checker: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the read stream.
module tb_aqed_rd_checker;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int CW   = 32;
  localparam int MAXO = 4;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic reset, clk_en, flush, exec_dup, wen_obs;
  logic qed_done, qed_check, qed_abort, qed_hang, proto_err;

  aqed_rd_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  aqed_rd_checker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .exec_dup(exec_dup), .wen_obs(wen_obs), .bus(bus),
    .qed_done(qed_done), .qed_check(qed_check), .qed_abort(qed_abort),
    .qed_hang(qed_hang), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one tag per read in flight (0 plain, 1 original, 2 duplicate)
  // and a phase for the original/duplicate episode (0 none, 1 original seen,
  // 2 duplicate in flight, 3 finished).
  int              tagq[$];
  logic [AW-1:0]   coreq[$];
  int              phase;
  int              waited;
  logic [AW-1:0]   m_orig_addr;
  logic [DW-1:0]   m_orig_data, m_dup_data;
  bit              got_o, got_d;
  bit              e_done, e_abort, e_hang, e_perr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return DW'(a) ^ 16'hA5C3;
  endfunction

  task automatic modelReset();
    tagq.delete();
    coreq.delete();
    phase = 0; waited = 0;
    m_orig_addr = '0; m_orig_data = '0; m_dup_data = '0;
    got_o = 0; got_d = 0;
    e_done = 0; e_abort = 0; e_hang = 0; e_perr = 0;
  endtask

  task automatic modelStep(input bit iss, input logic [AW-1:0] sent_addr);
    int  old_phase;
    int  tag;
    bit  entered;
    old_phase = phase;
    entered   = 0;
    if (old_phase == 1 && wen_obs) begin
      phase = 3;
      e_abort = 1;
    end
    if (iss) begin
      tag = 0;
      if (exec_dup && old_phase == 0) begin
        tag = 1; phase = 1; m_orig_addr = bus.addr_in;
      end else if (exec_dup && old_phase == 1 && !wen_obs) begin
        tag = 2; phase = 2; waited = 0; entered = 1;
      end
      tagq.push_back(tag);
      coreq.push_back(sent_addr);
    end
    if (bus.valid_in) begin
      if (tagq.size() > 0) begin
        tag = tagq.pop_front();
        void'(coreq.pop_front());
        if (tag == 1) begin m_orig_data = bus.data_in; got_o = 1; end
        if (tag == 2) begin m_dup_data  = bus.data_in; got_d = 1; end
      end else begin
        e_perr = 1;
      end
    end
    if (phase == 2) begin
      if (got_o && got_d) begin
        phase = 3; e_done = 1;
      end else if (!entered) begin
        waited++;
        if (waited == TO) begin phase = 3; e_hang = 1; end
      end
    end
  endtask

  // One clock cycle with the inputs already driven: check the combinational
  // request path, clock, advance the model, check the flags.
  task automatic applyStimulus();
    bit            iss;
    logic [AW-1:0] ea;
    #1;
    iss = bus.ren_in && !flush && (tagq.size() < MAXO);
    ea  = (iss && phase == 1 && exec_dup) ? m_orig_addr : bus.addr_in;
    checkOutput("ren_ready", bus.ren_ready, (tagq.size() < MAXO));
    checkOutput("ren_out", bus.ren_out, iss);
    checkOutput("addr_out", bus.addr_out, ea);
    @(posedge clk);
    if (clk_en) modelStep(iss, ea);
    #1;
    checkOutput("qed_done", qed_done, e_done);
    checkOutput("qed_check", qed_check, e_done && (m_orig_data == m_dup_data));
    checkOutput("qed_abort", qed_abort, e_abort);
    checkOutput("qed_hang", qed_hang, e_hang);
    checkOutput("proto_err", proto_err, e_perr);
  endtask

  task automatic set_in(input bit ce, input bit fl, input bit ed, input bit ren,
                        input logic [AW-1:0] a, input bit wen, input bit vld,
                        input logic [DW-1:0] d);
    clk_en = ce; flush = fl; exec_dup = ed; wen_obs = wen;
    bus.ren_in = ren; bus.addr_in = a; bus.valid_in = vld; bus.data_in = d;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ren_out"}, bus.ren_out, 0);
    checkOutput({tag, "_addr_out"}, bus.addr_out, 0);
    checkOutput({tag, "_ren_ready"}, bus.ren_ready, 0);
    checkOutput({tag, "_done"}, qed_done, 0);
    checkOutput({tag, "_check"}, qed_check, 0);
    checkOutput({tag, "_abort"}, qed_abort, 0);
    checkOutput({tag, "_hang"}, qed_hang, 0);
    checkOutput({tag, "_perr"}, proto_err, 0);
  endtask

  task automatic releaseReset();
    set_in(0, 0, 0, 0, '0, 0, 0, '0);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    set_in(0, 0, 0, 1, 16'h00FF, 0, 0, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkAllZero("rst");
    releaseReset();
  endtask

  task automatic matchSequence(input logic [DW-1:0] dup_d, input bit exp_check);
    set_in(1, 0, 1, 1, 16'h0010, 0, 0, '0); applyStimulus();
    set_in(1, 0, 1, 1, 16'h0044, 0, 0, '0);
    #1 checkOutput("dup_addr_out", bus.addr_out, 16'h0010);
    applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 0, '0);        applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 1, 16'hBEEF);  applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 1, dup_d);     applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 0, '0);        applyStimulus();
    checkOutput("seq_done", qed_done, 1);
    checkOutput("seq_check", qed_check, exp_check);
  endtask

  initial begin
    int counted;
    reset = 1'b0;
    modelReset();
    set_in(0, 0, 0, 0, '0, 0, 0, '0);
    #12;

    $display("[TB] basic match");
    doReset();
    matchSequence(16'hBEEF, 1);

    $display("[TB] mismatch");
    doReset();
    matchSequence(16'hBEEE, 0);

    $display("[TB] abort");
    doReset();
    set_in(1, 0, 1, 1, 16'h0030, 0, 0, '0);  applyStimulus();
    set_in(1, 0, 0, 0, '0, 1, 0, '0);        applyStimulus();
    set_in(1, 0, 1, 1, 16'h0031, 0, 0, '0);  applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 1, 16'h1111);  applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 1, 16'h1111);  applyStimulus();
    checkOutput("abort_flag", qed_abort, 1);
    checkOutput("abort_no_done", qed_done, 0);

    $display("[TB] backpressure");
    doReset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 1, AW'(i), 0, 0, '0); applyStimulus();
    end
    set_in(1, 0, 0, 1, 16'h0005, 0, 0, '0);
    #1 checkOutput("bp_ready_full", bus.ren_ready, 0);
    checkOutput("bp_fifth_ren_out", bus.ren_out, 0);
    applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 1, 16'h2222);  applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 0, '0);
    #1 checkOutput("bp_ready_restored", bus.ren_ready, 1);
    set_in(1, 0, 0, 1, 16'h0006, 0, 1, 16'h2222); applyStimulus();
    set_in(1, 0, 0, 1, 16'h0007, 0, 0, '0);       applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 0, '0);
    #1 checkOutput("bp_ready_refull", bus.ren_ready, 0);

    $display("[TB] hang");
    doReset();
    set_in(1, 0, 1, 1, 16'h0020, 0, 0, '0);  applyStimulus();
    set_in(1, 0, 0, 0, '0, 0, 1, 16'h1234);  applyStimulus();
    set_in(1, 0, 1, 1, 16'h0099, 0, 0, '0);  applyStimulus();
    counted = 0;
    for (int i = 0; i < 200 && counted < TO - 1; i++) begin
      set_in((i % 4) != 3, 0, 0, 0, '0, 0, 0, '0);
      if (clk_en) counted++;
      applyStimulus();
    end
    checkOutput("hang_not_yet", qed_hang, 0);
    set_in(1, 0, 0, 0, '0, 0, 0, '0);        applyStimulus();
    checkOutput("hang_flag", qed_hang, 1);

    $display("[TB] protocol error");
    doReset();
    set_in(1, 0, 0, 0, '0, 0, 1, 16'h3333);  applyStimulus();
    checkOutput("perr_flag", proto_err, 1);
    set_in(1, 0, 0, 0, '0, 0, 0, '0);
    #1 checkOutput("perr_ready", bus.ren_ready, 1);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 1, AW'(i), 0, 0, '0); applyStimulus();
    end
    set_in(1, 0, 0, 0, '0, 0, 0, '0);
    #1 checkOutput("perr_no_underflow", bus.ren_ready, 0);

    $display("[TB] async reset mid-duplicate");
    doReset();
    set_in(1, 0, 1, 1, 16'h0010, 0, 0, '0);  applyStimulus();
    set_in(1, 0, 1, 1, 16'h0010, 0, 0, '0);  applyStimulus();
    set_in(1, 0, 1, 1, 16'h0033, 0, 0, '0);
    #3 reset = 1'b0;
    #1 checkAllZero("async");
    releaseReset();
    matchSequence(16'hBEEF, 1);

    $display("[TB] randomized traffic");
    for (int ep = 0; ep < 6; ep++) begin
      doReset();
      for (int c = 0; c < 180; c++) begin
        clk_en      = ($urandom_range(0, 99) < 85);
        flush       = ($urandom_range(0, 99) < 10);
        exec_dup    = ($urandom_range(0, 99) < 25);
        wen_obs     = ($urandom_range(0, 99) < 3);
        bus.ren_in  = ($urandom_range(0, 99) < 50);
        bus.addr_in = AW'($urandom_range(0, 15)) << 4;
        if (coreq.size() > 0 && $urandom_range(0, 99) < 40) begin
          bus.valid_in = 1'b1;
          bus.data_in  = mem_val(coreq[0]) ^ DW'(($urandom_range(0, 99) < 15) ? 1 : 0);
        end else if (coreq.size() == 0 && $urandom_range(0, 99) < 4) begin
          bus.valid_in = 1'b1;
          bus.data_in  = DW'($urandom);
        end else begin
          bus.valid_in = 1'b0;
          bus.data_in  = '0;
        end
        applyStimulus();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
